// File: rtl/result_collect.sv
// result_collect: round-robin gatherer of worker pixel results, FIFO-buffered frame-buffer writer.
// Optional RESULT_COLOR_MAP_EN maps iteration counts to an RGB332 palette at FIFO pop.
module result_collect #(
  parameter int NUM_WORKERS = 16,
  parameter int ITER_W      = 8,
  parameter int ITER_MAX    = 255,
  parameter int FIFO_DEPTH  = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               start,
  input  logic [NUM_WORKERS-1:0]             jw_cl_done,
  input  logic [0:NUM_WORKERS-1][9:0]        jw_cl_x,
  input  logic [0:NUM_WORKERS-1][9:0]        jw_cl_y,
  input  logic [0:NUM_WORKERS-1][ITER_W-1:0] jw_cl_iter,
  output logic [NUM_WORKERS-1:0]             cl_jw_ack,
  output logic                               fb_wr_en,
  output logic [18:0]                        fb_wr_addr,
  output logic [ITER_W-1:0]                  fb_wr_data,
  input  logic                               fb_wr_ack,
  output logic                               frame_done,
  output logic                               err_range
);

  localparam int PTR_W = $clog2(NUM_WORKERS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C      = (AW+1)'(FIFO_DEPTH);
  localparam logic [18:0] FRAME_PIXELS = 19'((X_MAX + 1) * (Y_MAX + 1));

`ifdef RESULT_COLOR_MAP_EN
  localparam bit COLOR_MAP = 1'b1;
`else
  localparam bit COLOR_MAP = 1'b0;
`endif

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand;
  logic                   grant_valid;
  logic                   arb_en;
  logic                   in_range;
  logic                   push;
  logic                   pop;
  logic [NUM_WORKERS-1:0] eligible;

  logic [9:0]        fifo_x    [FIFO_DEPTH];
  logic [9:0]        fifo_y    [FIFO_DEPTH];
  logic [ITER_W-1:0] fifo_iter [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [18:0]       head_addr;
  logic [18:0]       pix_cnt;

  function automatic logic [ITER_W-1:0] map_pixel(input logic [ITER_W-1:0] it);
    if (COLOR_MAP && it == ITER_W'(ITER_MAX))
      return '0;
    else if (COLOR_MAP)
      return {it[2:0], it[5:3], it[7:6]};
    else
      return it;
  endfunction

  // A worker's done is still high during its own ack cycle, so it is masked out.
  assign eligible = jw_cl_done & ~cl_jw_ack;
  assign arb_en   = (count < DEPTH_C) && !start;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      cand = rr_ptr + PTR_W'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_valid = grant_valid && arb_en;
  end

  assign in_range  = (jw_cl_x[grant_idx] <= 10'(X_MAX)) && (jw_cl_y[grant_idx] <= 10'(Y_MAX));
  assign push      = grant_valid && in_range;
  assign pop       = (count != '0) && !start && (state == IDLE || fb_wr_ack);
  assign head_addr = ({9'd0, fifo_y[rd_ptr]} << 9) + ({9'd0, fifo_y[rd_ptr]} << 7)
                   + {9'd0, fifo_x[rd_ptr]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cl_jw_ack <= '0;
      rr_ptr    <= '0;
      err_range <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      cl_jw_ack <= '0;
      if (start) begin
        rr_ptr    <= '0;
        err_range <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
      end else begin
        if (grant_valid) begin
          cl_jw_ack <= NUM_WORKERS'(1) << grant_idx;
          rr_ptr    <= grant_idx + PTR_W'(1);
          if (!in_range)
            err_range <= 1'b1;
        end
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + (AW+1)'(1);
        else if (pop && !push)
          count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr]    <= jw_cl_x[grant_idx];
      fifo_y[wr_ptr]    <= jw_cl_y[grant_idx];
      fifo_iter[wr_ptr] <= jw_cl_iter[grant_idx];
    end
  end

  // Write FSM: fb_wr_en is high exactly while in WRITE, so ack is only honoured there.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state    <= IDLE;
        fb_wr_en <= 1'b0;
        pix_cnt  <= '0;
      end else begin
        if (fb_wr_en && fb_wr_ack) begin
          if (pix_cnt == FRAME_PIXELS - 19'd1) begin
            pix_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 19'd1;
          end
        end
        case (state)
          IDLE: begin
            if (pop) begin
              fb_wr_addr <= head_addr;
              fb_wr_data <= map_pixel(fifo_iter[rd_ptr]);
              fb_wr_en   <= 1'b1;
              state      <= WRITE;
            end
          end
          WRITE: begin
            if (fb_wr_ack) begin
              if (pop) begin
                fb_wr_addr <= head_addr;
                fb_wr_data <= map_pixel(fifo_iter[rd_ptr]);
              end else begin
                fb_wr_en <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          default: begin
            state    <= IDLE;
            fb_wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_result_collect.sv
// Directed bench for result_collect: a full-size instance plus a 4x2-pixel instance for frame completion.
module tb_result_collect;

  logic clk = 1'b0;
  logic n_rst;
  logic start;

  logic [15:0]       jw_cl_done;
  logic [0:15][9:0]  jw_cl_x;
  logic [0:15][9:0]  jw_cl_y;
  logic [0:15][7:0]  jw_cl_iter;
  logic [15:0]       cl_jw_ack;
  logic              fb_wr_en;
  logic [18:0]       fb_wr_addr;
  logic [7:0]        fb_wr_data;
  logic              fb_wr_ack;
  logic              frame_done;
  logic              err_range;

  logic [15:0]       s_done;
  logic [0:15][9:0]  s_x;
  logic [0:15][9:0]  s_y;
  logic [0:15][7:0]  s_iter;
  logic [15:0]       s_ack;
  logic              s_wr_en;
  logic [18:0]       s_addr;
  logic [7:0]        s_data;
  logic              s_wr_ack = 1'b1;
  logic              s_frame_done;
  logic              s_err;

  int compared   = 0;
  int mismatched = 0;
  int acks_seen;
  int writes;
  int pulses;

  always #5 clk = ~clk;

  result_collect dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .jw_cl_done (jw_cl_done),
    .jw_cl_x    (jw_cl_x),
    .jw_cl_y    (jw_cl_y),
    .jw_cl_iter (jw_cl_iter),
    .cl_jw_ack  (cl_jw_ack),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .fb_wr_ack  (fb_wr_ack),
    .frame_done (frame_done),
    .err_range  (err_range)
  );

  result_collect #(.X_MAX(3), .Y_MAX(1)) dut_small (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .jw_cl_done (s_done),
    .jw_cl_x    (s_x),
    .jw_cl_y    (s_y),
    .jw_cl_iter (s_iter),
    .cl_jw_ack  (s_ack),
    .fb_wr_en   (s_wr_en),
    .fb_wr_addr (s_addr),
    .fb_wr_data (s_data),
    .fb_wr_ack  (s_wr_ack),
    .frame_done (s_frame_done),
    .err_range  (s_err)
  );

  function automatic logic [7:0] expPixel(input logic [7:0] it);
`ifdef RESULT_COLOR_MAP_EN
    if (it == 8'hFF) return 8'h00;
    return {it[2:0], it[5:3], it[7:6]};
`else
    return it;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Workers drop done once they have seen their ack.
  task automatic nextCycle();
    @(negedge clk);
    jw_cl_done = jw_cl_done & ~cl_jw_ack;
    s_done     = s_done & ~s_ack;
  endtask

  task automatic applyStimulus(input int idx, input int x, input int y, input int it);
    jw_cl_x[idx]    = 10'(x);
    jw_cl_y[idx]    = 10'(y);
    jw_cl_iter[idx] = 8'(it);
    jw_cl_done[idx] = 1'b1;
  endtask

  task automatic applySmallStimulus(input int idx);
    s_x[idx]    = 10'(idx % 4);
    s_y[idx]    = 10'(idx / 4);
    s_iter[idx] = 8'(idx + 1);
    s_done[idx] = 1'b1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; fb_wr_ack = 1'b0;
    jw_cl_done = '0; jw_cl_x = '0; jw_cl_y = '0; jw_cl_iter = '0;
    s_done = '0; s_x = '0; s_y = '0; s_iter = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 32'(cl_jw_ack), 32'h0);
    checkOutput("rst_wr_en", 32'(fb_wr_en), 32'd0);
    checkOutput("rst_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("rst_data", 32'(fb_wr_data), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_err", 32'(err_range), 32'd0);

    // Single result from worker 3
    n_rst = 1'b1;
    fb_wr_ack = 1'b1;
    applyStimulus(3, 5, 2, 17);
    nextCycle();
    checkOutput("t1_ack", 32'(cl_jw_ack), 32'h0008);
    checkOutput("t1_wr_idle", 32'(fb_wr_en), 32'd0);
    nextCycle();
    checkOutput("t1_ack_once", 32'(cl_jw_ack), 32'h0);
    checkOutput("t1_wr_en", 32'(fb_wr_en), 32'd1);
    checkOutput("t1_addr", 32'(fb_wr_addr), 32'd1285);
    checkOutput("t1_data", 32'(fb_wr_data), 32'(expPixel(8'd17)));
    nextCycle();
    checkOutput("t1_wr_drop", 32'(fb_wr_en), 32'd0);

    // Round-robin order from pointer 0, then from pointer 8
    pulseStart();
    applyStimulus(0, 1, 0, 1);
    applyStimulus(7, 7, 0, 2);
    applyStimulus(15, 15, 0, 3);
    nextCycle(); checkOutput("t2_rr0_a", 32'(cl_jw_ack), 32'h0001);
    nextCycle(); checkOutput("t2_rr0_b", 32'(cl_jw_ack), 32'h0080);
    nextCycle(); checkOutput("t2_rr0_c", 32'(cl_jw_ack), 32'h8000);
    nextCycle(); checkOutput("t2_rr0_end", 32'(cl_jw_ack), 32'h0);
    repeat (4) nextCycle();
    applyStimulus(7, 7, 1, 4);
    nextCycle(); checkOutput("t2_set_ptr", 32'(cl_jw_ack), 32'h0080);
    nextCycle(); checkOutput("t2_gap", 32'(cl_jw_ack), 32'h0);
    applyStimulus(0, 1, 1, 5);
    applyStimulus(7, 7, 1, 6);
    applyStimulus(15, 15, 1, 7);
    nextCycle(); checkOutput("t2_rr8_a", 32'(cl_jw_ack), 32'h8000);
    nextCycle(); checkOutput("t2_rr8_b", 32'(cl_jw_ack), 32'h0001);
    nextCycle(); checkOutput("t2_rr8_c", 32'(cl_jw_ack), 32'h0080);
    repeat (6) nextCycle();

    // Stalled frame buffer with every worker done
    fb_wr_ack = 1'b0;
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(i, i * 3, i + 1, i * 16 + 1);
    acks_seen = 0;
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      acks_seen += $countones(cl_jw_ack);
      if (k >= 1) begin
        checkOutput("t3_hold_en", 32'(fb_wr_en), 32'd1);
        checkOutput("t3_hold_addr", 32'(fb_wr_addr), 32'd640);
        checkOutput("t3_hold_data", 32'(fb_wr_data), 32'(expPixel(8'd1)));
      end
    end
    checkOutput("t3_stall_acks", 32'(acks_seen), 32'd5);
    fb_wr_ack = 1'b1;
    writes = 0;
    for (int k = 0; k < 60; k++) begin
      if (fb_wr_en) writes++;
      nextCycle();
      acks_seen += $countones(cl_jw_ack);
      if (k == 0) begin
        checkOutput("t3_pop_no_free", 32'(cl_jw_ack), 32'h0);
        checkOutput("t3_b2b_en", 32'(fb_wr_en), 32'd1);
        checkOutput("t3_b2b_addr", 32'(fb_wr_addr), 32'd1283);
        checkOutput("t3_b2b_data", 32'(fb_wr_data), 32'(expPixel(8'd17)));
      end
      if (k == 1) checkOutput("t3_resume_ack", 32'(cl_jw_ack), 32'h0020);
    end
    checkOutput("t3_total_writes", 32'(writes), 32'd16);
    checkOutput("t3_total_acks", 32'(acks_seen), 32'd16);

    // Frame completion on the 4x2 instance
    pulseStart();
    for (int i = 0; i < 7; i++) applySmallStimulus(i);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      nextCycle();
      if (s_frame_done) pulses++;
    end
    checkOutput("t4_no_early_done", 32'(pulses), 32'd0);
    applySmallStimulus(7);
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      if (s_frame_done) pulses++;
    end
    checkOutput("t4_frame_done", 32'(pulses), 32'd1);
    for (int i = 0; i < 8; i++) applySmallStimulus(i);
    for (int k = 0; k < 25; k++) begin
      nextCycle();
      if (s_frame_done) pulses++;
    end
    checkOutput("t4_second_frame", 32'(pulses), 32'd2);
    checkOutput("t4_no_err", 32'(s_err), 32'd0);

    // Range boundaries and sticky error flag
    pulseStart();
    applyStimulus(1, 639, 479, 255);
    nextCycle(); checkOutput("t5_corner_ack", 32'(cl_jw_ack), 32'h0002);
    nextCycle();
    checkOutput("t5_corner_en", 32'(fb_wr_en), 32'd1);
    checkOutput("t5_corner_addr", 32'(fb_wr_addr), 32'd307199);
    checkOutput("t5_corner_data", 32'(fb_wr_data), 32'(expPixel(8'd255)));
    checkOutput("t5_corner_no_err", 32'(err_range), 32'd0);
    nextCycle();
    applyStimulus(2, 640, 0, 9);
    nextCycle();
    checkOutput("t5_bad_x_ack", 32'(cl_jw_ack), 32'h0004);
    checkOutput("t5_bad_x_err", 32'(err_range), 32'd1);
    nextCycle(); nextCycle();
    checkOutput("t5_bad_x_no_write", 32'(fb_wr_en), 32'd0);
    applyStimulus(4, 0, 0, 8'h6B);
    nextCycle(); checkOutput("t5_map_ack", 32'(cl_jw_ack), 32'h0010);
    nextCycle();
    checkOutput("t5_map_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("t5_map_data", 32'(fb_wr_data), 32'(expPixel(8'h6B)));
    checkOutput("t5_err_sticky", 32'(err_range), 32'd1);
    nextCycle();
    pulseStart();
    checkOutput("t5_err_cleared", 32'(err_range), 32'd0);
    applyStimulus(6, 0, 480, 3);
    nextCycle(); checkOutput("t5_bad_y_err", 32'(err_range), 32'd1);
    nextCycle(); nextCycle();
    checkOutput("t5_bad_y_no_write", 32'(fb_wr_en), 32'd0);

    // start aborts a stalled write; reset mid-write clears outputs at once
    fb_wr_ack = 1'b0;
    applyStimulus(5, 1, 1, 40);
    nextCycle(); nextCycle();
    checkOutput("t6_wr_pending", 32'(fb_wr_en), 32'd1);
    pulseStart();
    checkOutput("t6_start_abort", 32'(fb_wr_en), 32'd0);
    applyStimulus(6, 2, 3, 4);
    nextCycle(); nextCycle();
    checkOutput("t6_wr_addr", 32'(fb_wr_addr), 32'd1922);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("t6_rst_en", 32'(fb_wr_en), 32'd0);
    checkOutput("t6_rst_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("t6_rst_data", 32'(fb_wr_data), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
